// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port IDs and default parameters for the RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int RAM_LAT_DEF = 1;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first winner select with a saturating fetch starvation counter
// Ports: clk, reset (async, active-low); f_req/d_req requests; arb_en marks an arbitration edge;
//        win_valid = a port wins on this edge, win_id = PORT_F or PORT_D.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req,
  input  logic d_req,
  input  logic arb_en,
  output logic win_valid,
  output logic win_id
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  assign win_valid = arb_en && (f_req || d_req);
  // fetch wins when alone, or when it has lost STARVE_MAX arbitrations in a row
  assign win_id = (f_req && (!d_req || starve_cnt == SMAX)) ? PORT_F : PORT_D;
  always_ff @(posedge clk or negedge reset)
    if (!reset) starve_cnt <= '0;
    else if (win_valid)
      starve_cnt <= (win_id == PORT_F) ? '0 :
                    (f_req && starve_cnt != SMAX) ? starve_cnt + 4'd1 : starve_cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between an instruction-fetch port and a load/store data port
// Ports: clk, reset (async, active-low);
//        fetch: f_req/f_addr in, f_gnt/f_rvalid/f_rdata out;
//        data:  d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out;
//        RAM:   ram_we/ram_addr/ram_dataI out, ram_dataO in; busy = not idle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RAM_LAT    = RAM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataI,
  input  logic [DATA_W-1:0] ram_dataO,
  output logic              busy
);
  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);
  state_t     state;
  logic       win;
  logic       we_l;
  logic [2:0] lat_cnt;
  logic       win_valid;
  logic       win_id;
  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .reset    (reset),
    .f_req    (f_req),
    .d_req    (d_req),
    .arb_en   (state == IDLE || state == RESP),
    .win_valid(win_valid),
    .win_id   (win_id)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      win       <= PORT_F;
      we_l      <= 1'b0;
      lat_cnt   <= '0;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_dataI <= '0;
      busy      <= 1'b0;
    end else begin
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        IDLE, RESP:
          if (win_valid) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            win      <= win_id;
            f_gnt    <= win_id == PORT_F;
            d_gnt    <= win_id == PORT_D;
            we_l     <= win_id == PORT_D && d_we;
            ram_we   <= win_id == PORT_D && d_we;
            ram_addr <= (win_id == PORT_D) ? d_addr : f_addr;
            // fetch carries no write data, so the last store data is left in place
            if (win_id == PORT_D) ram_dataI <= d_wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        ACCESS: begin
          state   <= WAIT;
          lat_cnt <= LAT_LAST;
        end
        WAIT:
          if (lat_cnt == '0) begin
            state    <= RESP;
            f_rvalid <= win == PORT_F;
            d_rvalid <= win == PORT_D;
            if (win == PORT_F) f_rdata <= ram_dataO;
            else if (!we_l) d_rdata <= ram_dataO;
          end else lat_cnt <= lat_cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_chk = 0;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  function automatic logic [15:0] mem_init(input int a);
    return (a == 16) ? 16'hABCD : (16'(a * 40503) ^ 16'h5A5A);
  endfunction
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = g ? 3 : 1;
    logic rst, f_req, d_req, d_we, f_gnt, f_rvalid, d_gnt, d_rvalid, ram_we, busy;
    logic [15:0] f_addr, d_addr, d_wdata, f_rdata, d_rdata, ram_addr, ram_dataI, ram_dataO;
    logic [15:0] ram [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] pipe [L];
    logic fin = 1'b0;
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(L), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_dataI(ram_dataI), .ram_dataO(ram_dataO),
      .busy(busy)
    );
    // RAM: data for an address presented in one cycle appears L cycles later
    assign ram_dataO = pipe[L-1];
    always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_dataI;
      pipe[0] <= ram[ram_addr];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    // model: one transaction timeline (arbitration edge t0, response L+1 edges later)
    int cyc = 0, t0 = 0, free_at = 0, starve = 0;
    logic act = 1'b0, aid = 1'b0, awe = 1'b0;
    logic [15:0] aaddr = '0, adi = '0, pend = '0, frd = '0, drd = '0;
    always @(posedge clk) begin
      cyc++;
      if (!rst) begin
        act = 1'b0; starve = 0; free_at = 0; aaddr = '0; adi = '0; frd = '0; drd = '0;
      end else begin
        if (act && cyc == t0 + L + 1 && !awe) begin
          if (aid) drd = pend;
          else frd = pend;
        end
        if (cyc >= free_at && (f_req || d_req)) begin
          aid = !(f_req && (!d_req || starve == 4));
          if (!aid) starve = 0;
          else if (f_req && starve < 4) starve++;
          t0 = cyc;
          act = 1'b1;
          free_at = cyc + L + 2;
          awe = aid && d_we;
          aaddr = aid ? d_addr : f_addr;
          if (aid) adi = d_wdata;
          if (awe) ref_mem[aaddr] = d_wdata;
          else pend = ref_mem[aaddr];
        end
      end
    end
    logic on;
    logic [69:0] ev, gv;
    always @(negedge clk) begin
      on = act && (cyc - t0 <= L + 1);
      ev = {on && cyc == t0 && !aid, on && cyc == t0 + L + 1 && !aid, frd,
            on && cyc == t0 && aid, on && cyc == t0 + L + 1 && aid, drd,
            on && cyc == t0 && awe, aaddr, adi, on};
      gv = {f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, ram_we, ram_addr, ram_dataI, busy};
      check($sformatf("i%0d cyc%0d outputs", g, cyc), gv, rst ? ev : 70'd0);
    end
    initial begin
      int k, cnt;
      int tg [4];
      logic [9:0] pattern;
      logic fg, dg;
      rst = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 65536; i++) begin
        ram[i] <= mem_init(i);
        ref_mem[i] = mem_init(i);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      // fetch read of a preset word
      @(posedge clk); #1 f_req = 1'b1; f_addr = 16'h0010;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (f_gnt) break; end
      check($sformatf("i%0d fetch gnt", g), f_gnt, 1);
      check($sformatf("i%0d fetch ram_addr", g), ram_addr, 16'h0010);
      @(posedge clk); #1 f_req = 1'b0;
      k = 0;
      for (int n = 0; n < 20; n++) begin @(negedge clk); k++; if (f_rvalid) break; end
      check($sformatf("i%0d fetch latency", g), k, L + 1);
      check($sformatf("i%0d fetch rdata", g), f_rdata, 16'hABCD);
      // store then load back
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (d_gnt) break; end
      check($sformatf("i%0d store we", g), {ram_we, ram_addr, ram_dataI}, {1'b1, 16'h0020, 16'h1234});
      @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check($sformatf("i%0d store we one cycle", g), ram_we, 0);
      for (int n = 0; n < 20; n++) begin if (d_rvalid) break; @(negedge clk); end
      check($sformatf("i%0d store rvalid", g), d_rvalid, 1);
      @(posedge clk); #1 d_req = 1'b1; d_addr = 16'h0020;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (d_gnt) break; end
      @(posedge clk); #1 d_req = 1'b0;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (d_rvalid) break; end
      check($sformatf("i%0d load rdata", g), d_rdata, 16'h1234);
      // simultaneous requests: data first, fetch one access period later
      @(posedge clk); #1 f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0030; d_addr = 16'h0040;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (f_gnt || d_gnt) break; end
      check($sformatf("i%0d simul first gnt", g), {f_gnt, d_gnt}, 2'b01);
      @(posedge clk); #1 d_req = 1'b0;
      k = 0;
      for (int n = 0; n < 20; n++) begin @(negedge clk); k++; if (f_gnt) break; end
      check($sformatf("i%0d simul fetch gap", g), k, L + 2);
      @(posedge clk); #1 f_req = 1'b0;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (!busy) break; end
      // starvation guard: four data grants, then one fetch grant, repeating
      @(posedge clk); #1 f_req = 1'b1; d_req = 1'b1;
      pattern = '0; cnt = 0;
      for (int n = 0; n < 200 && cnt < 10; n++) begin
        @(negedge clk);
        if (f_gnt || d_gnt) begin pattern[cnt] = f_gnt; cnt++; end
      end
      @(posedge clk); #1 f_req = 1'b0; d_req = 1'b0;
      check($sformatf("i%0d starve pattern", g), pattern, 10'h210);
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (!busy) break; end
      // fetch held high: one grant per access period
      @(posedge clk); #1 f_req = 1'b1; f_addr = 16'h0050;
      cnt = 0;
      for (int n = 0; n < 100 && cnt < 4; n++) begin
        @(negedge clk);
        if (f_gnt) begin tg[cnt] = cyc; cnt++; end
      end
      @(posedge clk); #1 f_req = 1'b0;
      for (int i = 0; i < 3; i++) check($sformatf("i%0d held fetch gap%0d", g, i), tg[i+1] - tg[i], L + 2);
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (!busy) break; end
      // reset while a load is waiting on the RAM
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
      for (int n = 0; n < 20; n++) begin @(negedge clk); if (d_gnt) break; end
      @(posedge clk); #1 d_req = 1'b0;
      #1 rst = 1'b0;
      #1 check($sformatf("i%0d async reset", g),
               {busy, ram_we, d_rvalid, ram_addr, d_rdata, f_rdata}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) @(negedge clk);
      check($sformatf("i%0d idle after reset", g), {busy, d_rvalid}, 0);
      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk); fg = f_gnt; dg = d_gnt;
        @(posedge clk); #1;
        if (!f_req) begin
          if ($urandom_range(1) == 1) begin
            f_req = 1'b1;
            f_addr = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(31));
          end
        end else if (fg) begin
          if ($urandom_range(1) == 1) f_addr = 16'($urandom_range(31));
          else f_req = 1'b0;
        end else if ($urandom_range(7) == 0) f_req = 1'b0;
        if (!d_req || dg) begin
          d_req = (!d_req) ? ($urandom_range(1) == 1) : ($urandom_range(1) == 1);
          d_we = 1'($urandom_range(1));
          d_wdata = 16'($urandom);
          d_addr = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(31));
        end else if ($urandom_range(7) == 0) d_req = 1'b0;
      end
      @(posedge clk); #1 f_req = 1'b0; d_req = 1'b0;
      repeat (10) @(posedge clk);
      fin = 1'b1;
    end
  end
  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (inst[0].fin && inst[1].fin) break;
    end
    if (!(inst[0].fin && inst[1].fin)) check("run finished", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
